// File: rtl/rnn_mem_responder.sv
// rnn_mem_responder: memory-side companion to the RNN engine. Holds the
// weight/bias banks, the step count, the x input stream and the result bank.
// It also sequences a run handshake (IDLE -> ARM -> RUN -> DONE).
// Optional checker: define RNN_MEM_CHECK_EN to enable the sticky err flags.
// With the macro undefined, err is tied to 0.
//
// state | meaning
// IDLE  | host preload allowed, waiting for start
// ARM   | ready raised, waiting for engine busy
// RUN   | engine running, x stream advances on i_en
// DONE  | one-cycle done pulse
module rnn_mem_responder #(
  parameter int X_DEPTH   = 64,
  parameter int OUT_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ready,
  input  logic        busy,
  input  logic        i_en,
  output logic [31:0] idata,
  input  logic        mce,
  input  logic [2:0]  msel,
  input  logic [16:0] maddr,
  output logic [19:0] mdata_r,
  input  logic [19:0] mdata_w,
  input  logic        ld_en,
  input  logic [2:0]  ld_sel,
  input  logic [16:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic        start,
  output logic        done,
  input  logic [11:0] rb_addr,
  output logic [19:0] rb_data,
  output logic [3:0]  err
);

  localparam int XW = $clog2(X_DEPTH);
  localparam int OW = $clog2(OUT_DEPTH);
  localparam logic [16:0] D_WIH = 17'd2048;
  localparam logic [16:0] D_BIH = 17'd64;
  localparam logic [16:0] D_WHH = 17'd4096;
  localparam logic [16:0] D_BHH = 17'd64;
  localparam logic [16:0] D_X   = 17'(X_DEPTH);
  localparam logic [16:0] D_OUT = 17'(OUT_DEPTH);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [19:0] w_ih [2048];
  logic [19:0] b_ih [64];
  logic [19:0] w_hh [4096];
  logic [19:0] b_hh [64];
  logic [19:0] step_cnt;
  logic [31:0] x_mem [X_DEPTH];
  logic [19:0] res_mem [OUT_DEPTH];

  logic [15:0] xptr;
  logic        ld_ok;
  logic        take_start;

  assign ld_ok      = ld_en && (state == IDLE);
  assign take_start = (state == IDLE) && start && !ld_en;

  // State register; reset returns to IDLE even mid-run
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (take_start) state_nxt = ARM;
      ARM:  if (busy)       state_nxt = RUN;
      RUN:  if (!busy)      state_nxt = DONE;
      DONE:                 state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    ready = (state == ARM);
    done  = (state == DONE);
  end

  // x stream pointer: cleared on accepted start, free-running count in RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      xptr <= '0;
    else if (take_start)             xptr <= '0;
    else if (state == RUN && i_en)   xptr <= xptr + 16'd1;
  end

  // Past the end of the stream there is no word to present, so drive 0
  assign idata = (17'(xptr) < D_X) ? x_mem[xptr[XW-1:0]] : 32'h0;

  // Host preload of the read-only banks; not cleared by reset
  always_ff @(posedge clk) begin
    if (ld_ok) begin
      case (ld_sel)
        3'b000: if (ld_addr < D_WIH) w_ih[ld_addr[10:0]] <= ld_data[19:0];
        3'b001: if (ld_addr < D_BIH) b_ih[ld_addr[5:0]]  <= ld_data[19:0];
        3'b010: if (ld_addr < D_WHH) w_hh[ld_addr[11:0]] <= ld_data[19:0];
        3'b011: if (ld_addr < D_BHH) b_hh[ld_addr[5:0]]  <= ld_data[19:0];
        3'b100: if (ld_addr == '0)   step_cnt            <= ld_data[19:0];
        3'b110: if (ld_addr < D_X)   x_mem[ld_addr[XW-1:0]] <= ld_data;
        default: ;
      endcase
    end
  end

  // Result bank: engine write wins over a simultaneous host preload
  always_ff @(posedge clk) begin
    if (mce && msel == 3'b101)
      res_mem[maddr[OW-1:0]] <= mdata_w;
    else if (ld_ok && ld_sel == 3'b101 && ld_addr < D_OUT)
      res_mem[ld_addr[OW-1:0]] <= ld_data[19:0];
  end

  assign rb_data = res_mem[rb_addr[OW-1:0]];

  // Combinational engine read port
  always_comb begin
    mdata_r = '0;
    if (mce) begin
      case (msel)
        3'b000: if (maddr < D_WIH) mdata_r = w_ih[maddr[10:0]];
        3'b001: if (maddr < D_BIH) mdata_r = b_ih[maddr[5:0]];
        3'b010: if (maddr < D_WHH) mdata_r = w_hh[maddr[11:0]];
        3'b011: if (maddr < D_BHH) mdata_r = b_hh[maddr[5:0]];
        3'b100: if (maddr == '0)   mdata_r = step_cnt;
        default: ;
      endcase
    end
  end

`ifdef RNN_MEM_CHECK_EN
  logic addr_oor;

  // Out-of-range decode for the engine port; result writes wrap, so never flagged
  always_comb begin
    addr_oor = 1'b0;
    case (msel)
      3'b000:  addr_oor = (maddr >= D_WIH);
      3'b001:  addr_oor = (maddr >= D_BIH);
      3'b010:  addr_oor = (maddr >= D_WHH);
      3'b011:  addr_oor = (maddr >= D_BHH);
      3'b100:  addr_oor = (maddr != '0);
      3'b101:  addr_oor = 1'b0;
      default: addr_oor = 1'b1;
    endcase
  end

  // Sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= '0;
    end else begin
      if (state == RUN && i_en && 17'(xptr) >= D_X) err[0] <= 1'b1;
      if (mce && addr_oor)                          err[1] <= 1'b1;
      if (ld_en && state != IDLE)                   err[2] <= 1'b1;
      if (ld_en && ld_sel == 3'b101 && busy)        err[3] <= 1'b1;
    end
  end
`else
  assign err = 4'b0000;
`endif

endmodule

// File: tb/tb_rnn_mem_responder.sv
// Directed bench for rnn_mem_responder: table of read-port vectors plus
// hand-written handshake, result-bank, reset and underflow sequences.
module tb_rnn_mem_responder;

`ifdef RNN_MEM_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        busy;
  logic        i_en;
  logic [31:0] idata;
  logic        mce;
  logic [2:0]  msel;
  logic [16:0] maddr;
  logic [19:0] mdata_r;
  logic [19:0] mdata_w;
  logic        ld_en;
  logic [2:0]  ld_sel;
  logic [16:0] ld_addr;
  logic [31:0] ld_data;
  logic        start;
  logic        done;
  logic [11:0] rb_addr;
  logic [19:0] rb_data;
  logic [3:0]  err;

  int total = 0;
  int bad   = 0;

  rnn_mem_responder #(.X_DEPTH(64), .OUT_DEPTH(4096)) dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy), .i_en(i_en),
    .idata(idata), .mce(mce), .msel(msel), .maddr(maddr), .mdata_r(mdata_r),
    .mdata_w(mdata_w), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .start(start), .done(done), .rb_addr(rb_addr),
    .rb_data(rb_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mce;
    logic [2:0]  msel;
    logic [16:0] maddr;
    logic [19:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] sel, input logic [16:0] addr, input logic [31:0] data);
    ld_en = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
    tick();
    ld_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; busy = 1'b0; i_en = 1'b0; mce = 1'b0; msel = '0; maddr = '0;
    mdata_w = '0; ld_en = 1'b0; ld_sel = '0; ld_addr = '0; ld_data = '0;
    start = 1'b0; rb_addr = '0;
    #12;
    chk("reset_ready", {31'b0, ready}, 32'h0);
    chk("reset_done",  {31'b0, done},  32'h0);
    chk("reset_err",   {28'b0, err},   32'h0);
    reset = 1'b1;
    tick();

    // Preload banks
    load(3'b000, 17'd0,    32'h0001_1111);
    load(3'b000, 17'd2047, 32'h0002_2222);
    load(3'b001, 17'd63,   32'h0003_3333);
    load(3'b010, 17'd4095, 32'hFFF1_2345);
    load(3'b011, 17'd5,    32'h0000_ABCD);
    load(3'b100, 17'd0,    32'h0000_0002);
    load(3'b101, 17'd7,    32'h0000_BEEF);
    load(3'b110, 17'd0,    32'hA5A5_0001);
    load(3'b110, 17'd1,    32'h0000_FFFF);
    load(3'b110, 17'd3,    32'h0000_0103);
    load(3'b110, 17'd4,    32'h0000_0104);
    load(3'b110, 17'd5,    32'h0000_0105);

    vecs[0]  = '{1'b1, 3'b000, 17'd0,    20'h11111};
    vecs[1]  = '{1'b1, 3'b000, 17'd2047, 20'h22222};
    vecs[2]  = '{1'b1, 3'b000, 17'd2048, 20'h00000};
    vecs[3]  = '{1'b1, 3'b001, 17'd63,   20'h33333};
    vecs[4]  = '{1'b1, 3'b001, 17'd64,   20'h00000};
    vecs[5]  = '{1'b1, 3'b010, 17'd4095, 20'h12345};
    vecs[6]  = '{1'b0, 3'b010, 17'd4095, 20'h00000};
    vecs[7]  = '{1'b1, 3'b011, 17'd5,    20'h0ABCD};
    vecs[8]  = '{1'b1, 3'b100, 17'd0,    20'h00002};
    vecs[9]  = '{1'b1, 3'b100, 17'd1,    20'h00000};
    vecs[10] = '{1'b1, 3'b101, 17'd7,    20'h00000};
    vecs[11] = '{1'b1, 3'b110, 17'd0,    20'h00000};

    mdata_w = 20'h0BEEF;
    for (int i = 0; i < 12; i++) begin
      mce = vecs[i].mce; msel = vecs[i].msel; maddr = vecs[i].maddr;
      #2;
      chk($sformatf("rd_vec%0d", i), {12'b0, mdata_r}, {12'b0, vecs[i].exp});
    end
    mce = 1'b0;
    rb_addr = 12'd7;
    #1;
    chk("rb_preload7", {12'b0, rb_data}, 32'h0BEEF);

    // Result bank write, plain and wrapped address
    tick();
    mce = 1'b1; msel = 3'b101; maddr = 17'h0041; mdata_w = 20'hF0000;
    tick();
    maddr = 17'd4162; mdata_w = 20'h0ABC5;
    tick();
    mce = 1'b0;
    rb_addr = 12'd65;
    #1;
    chk("rb_65", {12'b0, rb_data}, 32'hF0000);
    rb_addr = 12'd66;
    #1;
    chk("rb_66_wrap", {12'b0, rb_data}, 32'h0ABC5);

    // Basic run handshake
    tick();
    chk("idle_ready", {31'b0, ready}, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("arm_ready", {31'b0, ready}, 32'h1);
    chk("arm_done",  {31'b0, done},  32'h0);
    busy = 1'b1;
    tick();
    chk("run_ready", {31'b0, ready}, 32'h0);
    chk("idata0", idata, 32'hA5A5_0001);
    i_en = 1'b1;
    tick();
    chk("idata1", idata, 32'h0000_FFFF);
    tick();
    i_en = 1'b0;
    busy = 1'b0;
    tick();
    chk("done_pulse", {31'b0, done}, 32'h1);
    tick();
    chk("done_low", {31'b0, done}, 32'h0);
    chk("idle_again", {31'b0, ready}, 32'h0);

    // start together with a load: load taken, start ignored
    ld_en = 1'b1; ld_sel = 3'b110; ld_addr = 17'd2; ld_data = 32'h0000_0102; start = 1'b1;
    tick();
    ld_en = 1'b0;
    chk("start_with_ld", {31'b0, ready}, 32'h0);
    tick();
    start = 1'b0;
    chk("start_accepted", {31'b0, ready}, 32'h1);
    busy = 1'b1;
    tick();
    i_en = 1'b1;
    repeat (5) tick();
    i_en = 1'b0;
    chk("idata_xptr5", idata, 32'h0000_0105);
    ld_en = 1'b1; ld_sel = 3'b000; ld_addr = 17'd0; ld_data = 32'h000D_EAD0;
    tick();
    ld_en = 1'b0;
    chk("err2_ld_in_run", {31'b0, err[2]}, {31'b0, CHK});
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_run", {31'b0, ready}, 32'h0);

    // Reset mid-run
    reset = 1'b0;
    #2;
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_done",  {31'b0, done},  32'h0);
    chk("rst_err",   {28'b0, err},   32'h0);
    chk("rst_xptr",  idata, 32'hA5A5_0001);
    busy = 1'b0;
    #2;
    reset = 1'b1;
    tick();
    mce = 1'b1; msel = 3'b000; maddr = 17'd0;
    #1;
    chk("wih_intact", {12'b0, mdata_r}, 32'h11111);
    mce = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_rst_start", {31'b0, ready}, 32'h1);

    // Underflow: 65 i_en pulses on a 64-word stream
    busy = 1'b1;
    tick();
    i_en = 1'b1;
    repeat (64) tick();
    chk("err_before_65", {28'b0, err}, 32'h0);
    tick();
    i_en = 1'b0;
    chk("err0_underflow", {28'b0, err}, {31'b0, CHK});
    busy = 1'b0;
    tick();
    tick();
    chk("err0_sticky", {28'b0, err}, {31'b0, CHK});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
